// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if
//   Bundles the core-side request/response signals and the memory-side bus of
//   mem_access_unit.
//   Core side : req, we, size, signext, addr, wdata -> busy, done, rdata, err
//   Memory    : mem_a, mem_wd, mem_we -> memory ; mem_rd <- memory (combinational)
//   Modports  : slave  = the access unit itself
//               master = the environment (core + memory) around it
interface mem_access_unit_if;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        signext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] rdata;
    logic        err;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic        mem_we;
    logic [31:0] mem_rd;

    modport slave (
        input  req, we, size, signext, addr, wdata, mem_rd,
        output busy, done, rdata, err, mem_a, mem_wd, mem_we
    );

    modport master (
        output req, we, size, signext, addr, wdata, mem_rd,
        input  busy, done, rdata, err, mem_a, mem_wd, mem_we
    );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Byte/halfword/word load-store unit between a core and a word-wide memory
//   with combinational read data. Sub-word stores are done as read-modify-write.
//   Ports:
//     clk   - clock, rising edge
//     reset - asynchronous, active-high
//     bus   - mem_access_unit_if.slave (core request/response + memory bus)
//   Build option:
//     MEM_ACCESS_ALIGN_CHECK_EN - when defined, misaligned halfword/word accesses
//     and size=11 complete immediately with err=1 and touch no memory. When not
//     defined, err is tied 0, low address bits are ignored for wide accesses and
//     size=11 is treated as a word.
module mem_access_unit (
    input logic              clk,
    input logic              reset,
    mem_access_unit_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [1:0]  size_q;
    logic        we_q;
    logic        signext_q;
    logic [31:0] capWord_q;
    logic [31:0] rdata_q;

    logic        accept;
    logic        misaligned;
    logic [4:0]  laneShift;
    logic [31:0] laneMask;
    logic [31:0] laneData;
    logic [31:0] loadVal;

    assign accept = (state_q == StIdle) && bus.req;

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    logic err_q;

    assign misaligned = ((bus.size == 2'b01) && bus.addr[0]) ||
                        ((bus.size == 2'b10) && (bus.addr[1:0] != 2'b00)) ||
                        (bus.size == 2'b11);
    // err_q is rewritten on every accept, so it only needs qualifying with DONE.
    assign bus.err    = err_q && (state_q == StDone);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= misaligned;
        end
    end
`else
    assign misaligned = 1'b0;
    assign bus.err    = 1'b0;
`endif

    // size_q[1] set means word (10, or 11 when unchecked); size_q[0] picks halfword.
    always_comb begin
        laneShift = size_q[0] ? {addr_q[1], 4'b0000} : {addr_q[1:0], 3'b000};
        laneMask  = (size_q[0] ? 32'h0000_FFFF : 32'h0000_00FF) << laneShift;
        laneData  = bus.mem_rd >> laneShift;
        if (size_q[1]) begin
            loadVal = bus.mem_rd;
        end else if (size_q[0]) begin
            loadVal = {{16{signext_q & laneData[15]}}, laneData[15:0]};
        end else begin
            loadVal = {{24{signext_q & laneData[7]}}, laneData[7:0]};
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (bus.req) begin
                    if (misaligned) begin
                        state_d = StDone;
                    end else if (!bus.we || !bus.size[1]) begin
                        // Loads and sub-word stores both need the current word first.
                        state_d = StRead;
                    end else begin
                        state_d = StWrite;
                    end
                end
            end
            StRead:  state_d = we_q ? StWrite : StDone;
            StWrite: state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            size_q    <= '0;
            we_q      <= 1'b0;
            signext_q <= 1'b0;
            capWord_q <= '0;
            rdata_q   <= '0;
        end else begin
            if (accept) begin
                addr_q    <= bus.addr;
                wdata_q   <= bus.wdata;
                size_q    <= bus.size;
                we_q      <= bus.we;
                signext_q <= bus.signext;
            end
            if (state_q == StRead) begin
                capWord_q <= bus.mem_rd;
                if (!we_q) begin
                    rdata_q <= loadVal;
                end
            end
        end
    end

    assign bus.busy   = (state_q != StIdle);
    assign bus.done   = (state_q == StDone);
    assign bus.rdata  = rdata_q;
    assign bus.mem_a  = {addr_q[31:2], 2'b00};
    assign bus.mem_we = (state_q == StWrite);
    // Word stores pass wdata straight through; sub-word stores merge one lane.
    assign bus.mem_wd = size_q[1] ? wdata_q
                                  : ((capWord_q & ~laneMask) | ((wdata_q << laneShift) & laneMask));

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    logic clk = 1'b0;
    logic reset;

    mem_access_unit_if bus();

    mem_access_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          doneCyc;
    } doneItem_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wrItem_t;

    logic [31:0] tbMem   [16];
    logic [31:0] initVal [16];
    logic [31:0] refMem  [16];
    logic        memInit;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    bit          scoreOn = 1'b0;
    logic [31:0] lastRdata;
    doneItem_t   doneQ[$];
    wrItem_t     wrQ[$];
    doneItem_t   dItem;
    wrItem_t     wItem;

    // Memory model: combinational read, write at the edge ending a mem_we cycle.
    assign bus.mem_rd = tbMem[bus.mem_a[5:2]];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (memInit) begin
            for (int i = 0; i < 16; i++) tbMem[i] <= initVal[i];
        end else if (bus.mem_we) begin
            tbMem[bus.mem_a[5:2]] <= bus.mem_wd;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: pops on every write cycle and every done pulse.
    always @(negedge clk) begin
        if (scoreOn && !reset) begin
            if (bus.mem_we) begin
                total++;
                if (wrQ.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_write: got addr %h data %h expected no write",
                             bus.mem_a, bus.mem_wd);
                end else begin
                    wItem = wrQ.pop_front();
                    check("write_addr", bus.mem_a, wItem.addr);
                    check("write_data", bus.mem_wd, wItem.data);
                end
            end
            if (bus.done) begin
                total++;
                if (doneQ.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_done: got done=1 expected no pending op");
                end else begin
                    dItem = doneQ.pop_front();
                    check("done_rdata", bus.rdata, dItem.rdata);
                    check("done_err", 32'(bus.err), 32'(dItem.err));
                    check("done_cycle", cyc, dItem.doneCyc);
                end
            end
        end
    end

    // Issue one access (entered just after a negedge), model it, then keep req
    // toggling with junk operands while busy to show they are ignored.
    task automatic doOp(input logic w, input logic [1:0] sz, input logic sx,
                        input logic [31:0] a, input logic [31:0] wd, input bit holdAll);
        int          n;
        int          nb;
        int          off;
        int          lat;
        bit          mis;
        logic [3:0]  idx;
        logic [31:0] word;
        logic [31:0] val;
        @(negedge clk);
        n = 0;
        while (bus.busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (bus.busy) begin
            total++;
            bad++;
            $display("FAIL idle_wait: got busy=1 expected idle within 20 cycles");
            return;
        end
        bus.req     = 1'b1;
        bus.we      = w;
        bus.size    = sz;
        bus.signext = sx;
        bus.addr    = a;
        bus.wdata   = wd;

        mis = 1'b0;
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
        mis = ((sz == 2'd1) && a[0]) || ((sz == 2'd2) && (a[1:0] != 2'd0)) || (sz == 2'd3);
`endif
        nb   = (sz == 2'd0) ? 1 : ((sz == 2'd1) ? 2 : 4);
        off  = (int'(a[1:0]) / nb) * nb;
        idx  = a[5:2];
        word = refMem[idx];
        if (mis) begin
            lat = 1;
        end else if (!w) begin
            val = 32'h0;
            for (int b = 0; b < nb; b++) val |= ((word >> (8 * (off + b))) & 32'hFF) << (8 * b);
            if (sx && nb < 4 && val[8 * nb - 1]) val |= ~((32'h1 << (8 * nb)) - 32'h1);
            lastRdata = val;
            lat = 2;
        end else begin
            for (int b = 0; b < nb; b++) begin
                word = (word & ~(32'hFF << (8 * (off + b)))) |
                       (((wd >> (8 * b)) & 32'hFF) << (8 * (off + b)));
            end
            refMem[idx] = word;
            wrQ.push_back('{addr: {a[31:2], 2'b00}, data: word});
            lat = (nb == 4) ? 2 : 3;
        end
        doneQ.push_back('{rdata: lastRdata, err: mis, doneCyc: cyc + lat});

        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (!bus.busy) break;
            bus.req     = holdAll ? 1'b1 : 1'($urandom % 2);
            bus.we      = 1'($urandom % 2);
            bus.size    = 2'($urandom % 4);
            bus.signext = 1'($urandom % 2);
            bus.addr    = $urandom % 64;
            bus.wdata   = $urandom;
        end
        bus.req = 1'b0;
        if (bus.busy) begin
            total++;
            bad++;
            $display("FAIL op_finish: got busy=1 expected idle within 10 cycles");
        end
    endtask

    task automatic randOp();
        doOp(1'($urandom % 2), 2'($urandom % 4), 1'($urandom % 2), $urandom % 64, $urandom, 1'b0);
        repeat ($urandom % 3) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish before timeout");
        $fatal(1);
    end

    initial begin
        int n;
        bus.req = 1'b0; bus.we = 1'b0; bus.size = 2'd0; bus.signext = 1'b0;
        bus.addr = '0; bus.wdata = '0;
        for (int i = 0; i < 16; i++) initVal[i] = $urandom;
        initVal[1] = 32'h8899_AABB;
        initVal[2] = 32'h1122_3344;
        for (int i = 0; i < 16; i++) refMem[i] = initVal[i];
        lastRdata = 32'h0;
        reset   = 1'b1;
        memInit = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", 32'(bus.busy), 32'h0);
        check("reset_done", 32'(bus.done), 32'h0);
        check("reset_err", 32'(bus.err), 32'h0);
        check("reset_mem_we", 32'(bus.mem_we), 32'h0);
        check("reset_rdata", bus.rdata, 32'h0);
        check("reset_mem_a", bus.mem_a, 32'h0);
        memInit = 1'b0;
        reset   = 1'b0;
        scoreOn = 1'b1;

        doOp(1'b0, 2'd0, 1'b1, 32'h6, $urandom, 1'b0);
        check("load_byte_sext", bus.rdata, 32'hFFFF_FF99);
        doOp(1'b0, 2'd1, 1'b0, 32'h6, $urandom, 1'b0);
        check("load_half_zext", bus.rdata, 32'h0000_8899);
        doOp(1'b1, 2'd0, 1'b0, 32'h9, 32'h0000_00AB, 1'b0);
        check("store_byte_mem", tbMem[2], 32'h1122_AB44);
        check("store_keeps_rdata", bus.rdata, 32'h0000_8899);
        doOp(1'b1, 2'd2, 1'b0, 32'hC, 32'hDEAD_BEEF, 1'b1);
        check("store_word_mem", tbMem[3], 32'hDEAD_BEEF);
        doOp(1'b0, 2'd2, 1'b0, 32'h2, $urandom, 1'b0);
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
        check("misaligned_keeps_rdata", bus.rdata, 32'h0000_8899);
`else
        check("unaligned_word_load", bus.rdata, initVal[0]);
`endif

        for (int i = 0; i < 250; i++) randOp();

        // Abort a byte store during its write cycle.
        scoreOn = 1'b0;
        @(negedge clk);
        bus.req = 1'b1; bus.we = 1'b1; bus.size = 2'd0; bus.signext = 1'b0;
        bus.addr = 32'h9; bus.wdata = 32'h55;
        @(negedge clk);
        bus.req = 1'b0;
        n = 0;
        while (!bus.mem_we && n < 5) begin
            @(negedge clk);
            n++;
        end
        check("abort_reached_write", 32'(bus.mem_we), 32'h1);
        reset = 1'b1;
        #1;
        check("abort_mem_we", 32'(bus.mem_we), 32'h0);
        check("abort_busy", 32'(bus.busy), 32'h0);
        check("abort_rdata", bus.rdata, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        lastRdata = 32'h0;
        check("abort_word_unchanged", tbMem[2], refMem[2]);
        @(negedge clk);
        check("abort_no_replay", 32'(bus.mem_we), 32'h0);
        check("abort_idle", 32'(bus.busy), 32'h0);
        scoreOn = 1'b1;

        for (int i = 0; i < 30; i++) randOp();

        repeat (4) @(negedge clk);
        check("done_queue_empty", 32'(doneQ.size()), 32'h0);
        check("write_queue_empty", 32'(wrQ.size()), 32'h0);
        for (int i = 0; i < 16; i++) check("final_mem", tbMem[i], refMem[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1 bit: reset is asynchronous and active-high.
REQ-003 SHALL have port req, input, 1 bit: core access request, sampled only in IDLE.
REQ-004 SHALL have port we, input, 1 bit: 1 = store, 0 = load.
REQ-005 SHALL have port size, input, 2 bits: 00 = byte, 01 = halfword, 10 = word, 11 = reserved.
REQ-006 SHALL have port signext, input, 1 bit: 1 = sign-extend sub-word loads, 0 = zero-extend.
REQ-007 SHALL have port addr, input, 32 bits: byte address.
REQ-008 SHALL have port wdata, input, 32 bits: store data, right-justified.
REQ-009 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-010 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-011 SHALL have port rdata, output, 32 bits: registered, extended load result.
REQ-012 SHALL have port err, output, 1 bit: misalignment flag, valid only while done is high.
REQ-013 SHALL have port mem_a, output, 32 bits: word-aligned memory address {addr_q[31:2], 2'b00}.
REQ-014 SHALL have port mem_wd, output, 32 bits: memory write data.
REQ-015 SHALL have port mem_we, output, 1 bit: memory write enable; the memory writes on the clk edge ending the cycle in which mem_we is high.
REQ-016 SHALL have port mem_rd, input, 32 bits: combinational memory read data for mem_a.

Function
REQ-017 SHALL implement the states IDLE, READ, WRITE and DONE.
REQ-018 In IDLE with req=1, SHALL latch addr, wdata, size, we and signext into internal registers (suffix _q).
- A load SHALL go to READ.
- A word store SHALL go to WRITE.
- A byte or halfword store SHALL go to READ.
REQ-019 req SHALL be ignored in every state other than IDLE; latched operands SHALL NOT change mid-operation.
REQ-020 READ SHALL last one cycle with mem_we=0 and SHALL capture mem_rd at the ending edge.
- After a load, the next state SHALL be DONE and rdata SHALL be updated.
- After a sub-word store, the next state SHALL be WRITE.
REQ-021 WRITE SHALL last one cycle with mem_we=1, then SHALL go to DONE.
- mem_wd SHALL be wdata_q for a word store.
- For a sub-word store, mem_wd SHALL be the captured word with only the addressed lane replaced.
REQ-022 Byte lanes SHALL be little-endian: a byte selects bits [8*addr_q[1:0]+7 : 8*addr_q[1:0]]; a halfword selects bits [16*addr_q[1]+15 : 16*addr_q[1]].
REQ-023 DONE SHALL assert done=1 for exactly one cycle, then SHALL go to IDLE; a req present in that DONE cycle SHALL be ignored.
REQ-024 Latency from the accepting edge to the done pulse SHALL be:
- 2 cycles for a load,
- 2 cycles for a word store,
- 3 cycles for a sub-word store.
REQ-025 mem_we SHALL be 0 in every state except WRITE.
REQ-026 Stores SHALL leave rdata unchanged.

Reset
REQ-027 Asserting reset SHALL immediately force IDLE, and SHALL set busy=0, done=0, err=0, mem_we=0, rdata=0 and all _q registers to 0.
REQ-028 A reset during READ or WRITE SHALL abort the access with no memory write after reset assertion; an aborted sub-word store SHALL NOT be replayed.

Configuration
REQ-029 With MEM_ACCESS_ALIGN_CHECK_EN defined, the following accepts SHALL be misaligned: size=01 with addr[0]=1, size=10 with addr[1:0]≠00, and size=11.
- A misaligned accept SHALL go straight to DONE with err=1.
- It SHALL perform no READ/WRITE and SHALL leave rdata unchanged.
REQ-030 Without MEM_ACCESS_ALIGN_CHECK_EN, err SHALL be tied 0.
- A word access SHALL ignore addr[1:0].
- A halfword access SHALL ignore addr[0].
- size=11 SHALL behave as a word access.

Verification
REQ-031 Memory word 0x4 = 0x8899AABB; load byte, addr=0x6, signext=1 -> done 2 cycles after accept, rdata=0xFFFFFF99.
REQ-032 Same memory word; load halfword, addr=0x6, signext=0 -> rdata=0x00008899.
REQ-033 Memory word 0x8 = 0x11223344; store byte, addr=0x9, wdata=0xAB -> mem_we high exactly one cycle, mem_wd=0x1122AB44, done 3 cycles after accept.
REQ-034 Store word, addr=0xC, wdata=0xDEADBEEF, with req held high through DONE -> exactly one write of 0xDEADBEEF to mem_a=0xC and only one done pulse per accept.
REQ-035 Byte store in progress, reset asserted during WRITE -> mem_we drops the same cycle, target word unchanged, state IDLE, rdata=0.
REQ-036 Load word, addr=0x2, with MEM_ACCESS_ALIGN_CHECK_EN -> done next cycle, err=1, mem_we never asserted; without the macro -> mem_a=0x0 and the normal word is returned.
